agc_microseq: RTL and testbench

//  Parametrised AGC sequencer+datapath: owns A, Z (PC), Q, B, G, internal X/Y ALU.

---
 rtl/agc_pkg.sv | 11 +
 rtl/agc_mem_if.sv | 8 +
 rtl/agc_ones_alu.sv | 18 +
 rtl/agc_microseq.sv | 131 +++++++++++++
 tb/tb_agc_microseq.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/agc_pkg.sv
// agc_pkg: opcode and sequencer-state encodings plus instruction-word field widths
package agc_pkg;
  typedef enum logic [2:0] {
    OP_TC, OP_CCS, OP_INDEX, OP_XCH, OP_CS, OP_TS, OP_AD, OP_MASK
  } op_e;
  typedef enum logic [2:0] {
    S_HALT, S_FETCH, S_OPRD, S_EXEC, S_OPWR, S_RETIRE
  } state_e;
  localparam int OP_W = 3;
  localparam int SIGN_GAP = 1;
endpackage

// File: rtl/agc_mem_if.sv
// agc_mem_if: variable-latency req/ack memory port between sequencer and memory
interface agc_mem_if #(parameter int WORD_W = 16, parameter int ADDR_W = 12);
  logic mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata, mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/agc_ones_alu.sv
// agc_ones_alu: ones-complement add, magnitude-minus-one, negate and mask on X/Y
module agc_ones_alu #(parameter int W = 16) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o,
  output logic [W-1:0] dabs_o,
  output logic [W-1:0] neg_o,
  output logic [W-1:0] and_o
);
  logic [W:0] raw;
  assign raw    = {1'b0, x_i} + {1'b0, y_i};
  assign sum_o  = raw[W-1:0] + W'(raw[W]);
  assign ovf_o  = (x_i[W-1] == y_i[W-1]) && (sum_o[W-1] != x_i[W-1]);
  assign dabs_o = (y_i[W-1] ? ~y_i : y_i) - W'(1);
  assign neg_o  = ~y_i;
  assign and_o  = x_i & y_i;
endmodule

// File: rtl/agc_microseq.sv
// agc_microseq: AGC fetch/operand/execute/write sequencer with A/Z/Q/B/G registers
module agc_microseq
  import agc_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  agc_mem_if.master         mem,
  output logic [WORD_W-1:0] reg_a,
  output logic [ADDR_W-1:0] reg_z,
  output logic [WORD_W-1:0] reg_q,
  output logic              overflow,
  output logic              instr_done,
  output logic              halted
);
  state_e state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d, q_q, q_d, b_q, b_d, g_q, g_d, idx_q, idx_d;
  logic [ADDR_W-1:0] z_q, z_d, k;
  logic ovf_q, ovf_d;
  logic [WORD_W-1:0] alu_x, alu_y, alu_sum, alu_dabs, alu_neg, alu_and;
  logic alu_ovf, fetching, g_pz, g_nz, b_unused;
  logic [1:0] ccs_adv;
  op_e op, fetched_op;
  assign op         = op_e'(b_q[WORD_W-1-SIGN_GAP -: OP_W]);
  assign fetched_op = op_e'(alu_sum[WORD_W-1-SIGN_GAP -: OP_W]);
  assign k          = b_q[ADDR_W-1:0];
  assign b_unused   = b_q[WORD_W-1];
  assign fetching   = state_q == S_FETCH;
  // the ALU adds the pending index to the fetched word during FETCH, otherwise works on A and G
  assign alu_x = fetching ? mem.mem_rdata : a_q;
  assign alu_y = fetching ? idx_q : g_q;
  agc_ones_alu #(.W(WORD_W)) u_alu (
    .x_i(alu_x), .y_i(alu_y), .sum_o(alu_sum), .ovf_o(alu_ovf),
    .dabs_o(alu_dabs), .neg_o(alu_neg), .and_o(alu_and)
  );
  assign g_pz    = ~|g_q;
  assign g_nz    = &g_q;
  assign ccs_adv = g_q[WORD_W-1] ? (g_nz ? 2'd3 : 2'd2) : (g_pz ? 2'd1 : 2'd0);
  assign mem.mem_req   = state_q inside {S_FETCH, S_OPRD, S_OPWR};
  assign mem.mem_we    = state_q == S_OPWR;
  assign mem.mem_addr  = fetching ? z_q : k;
  assign mem.mem_wdata = a_q;
  assign reg_a      = a_q;
  assign reg_z      = z_q;
  assign reg_q      = q_q;
  assign overflow   = ovf_q;
  assign instr_done = state_q == S_RETIRE;
  assign halted     = state_q == S_HALT;
  // next-state and register updates; XCH loads A only once the old A has been written out
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    z_d = z_q;
    q_d = q_q;
    b_d = b_q;
    g_d = g_q;
    idx_d = idx_q;
    ovf_d = ovf_q;
    case (state_q)
      S_HALT: state_d = run ? S_FETCH : S_HALT;
      S_FETCH: if (mem.mem_ack) begin
        b_d = alu_sum;
        idx_d = '0;
        z_d = z_q + ADDR_W'(1);
        state_d = fetched_op == OP_TC ? S_EXEC : S_OPRD;
      end
      S_OPRD: if (mem.mem_ack) begin
        g_d = mem.mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_TC: begin
            q_d = WORD_W'(z_q);
            z_d = k;
          end
          OP_CCS: begin
            a_d = (g_pz | g_nz) ? '0 : alu_dabs;
            z_d = z_q + ADDR_W'(ccs_adv);
          end
          OP_INDEX: idx_d = g_q;
          OP_XCH: a_d = a_q;
          OP_CS: a_d = alu_neg;
          OP_TS: if (ovf_q) begin
            z_d = z_q + ADDR_W'(1);
            ovf_d = 1'b0;
          end
          OP_AD: begin
            a_d = alu_sum;
            ovf_d = ovf_q | alu_ovf;
          end
          OP_MASK: a_d = alu_and;
          default: a_d = a_q;
        endcase
        state_d = (op == OP_XCH || op == OP_TS) ? S_OPWR : S_RETIRE;
      end
      S_OPWR: if (mem.mem_ack) begin
        a_d = op == OP_XCH ? g_q : a_q;
        state_d = S_RETIRE;
      end
      S_RETIRE: state_d = run ? S_FETCH : S_HALT;
      default: state_d = S_HALT;
    endcase
  end
  // state and register file; reset aborts any in-flight access by returning to HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HALT;
      a_q <= '0;
      z_q <= RESET_PC;
      q_q <= '0;
      b_q <= '0;
      g_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      z_q <= z_d;
      q_q <= q_d;
      b_q <= b_d;
      g_q <= g_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_agc_microseq.sv
// tb_agc_microseq: directed vector table plus hand sequences against a req/ack memory model
module tb_agc_microseq;
  logic clk = 0, rst_n = 0, run = 0;
  always #5 clk = ~clk;
  agc_mem_if #(.WORD_W(16), .ADDR_W(12)) m ();
  logic [15:0] reg_a, reg_q;
  logic [11:0] reg_z;
  logic overflow, instr_done, halted;
  agc_microseq #(.WORD_W(16), .ADDR_W(12), .RESET_PC(12'h800)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem(m), .reg_a(reg_a), .reg_z(reg_z),
    .reg_q(reg_q), .overflow(overflow), .instr_done(instr_done), .halted(halted)
  );
  logic [15:0] mem [0:4095];
  int nvec = 0, nerr = 0, done_cnt = 0, last_lat = 0, wr_dly = 0, cnt = 0, dly = 0;
  bit rnd_dly = 0, pend = 0, unstable = 0;
  logic [11:0] c_addr;
  logic c_we;
  logic [15:0] c_wdata;
  initial begin
    m.mem_ack = 0;
    m.mem_rdata = 0;
  end
  // memory model: ack after a programmed delay, commit writes once the ack was seen by the DUT
  always @(negedge clk) begin
    if (m.mem_ack) begin
      if (rst_n && c_we) mem[c_addr] = c_wdata;
      m.mem_ack = 0;
      pend = 0;
    end
    if (m.mem_req && rst_n) begin
      if (!pend) begin
        pend = 1;
        c_addr = m.mem_addr;
        c_we = m.mem_we;
        c_wdata = m.mem_wdata;
        cnt = 0;
        dly = rnd_dly ? int'($urandom_range(5)) : (m.mem_we ? wr_dly : 0);
      end else if ({c_addr, c_we, c_wdata} != {m.mem_addr, m.mem_we, m.mem_wdata}) unstable = 1;
      if (cnt >= dly) begin
        m.mem_ack = 1;
        m.mem_rdata = mem[c_addr];
      end else cnt++;
    end else pend = 0;
  end
  always @(negedge clk) if (instr_done) done_cnt++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset;
    rst_n = 0;
    run = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic clr_mem;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
  endtask
  task automatic run_n(input int n);
    int done = 0, cyc = 0, budget = 0;
    run = 1;
    while (done < n && budget < 500) begin
      @(negedge clk);
      budget++;
      if (!halted) cyc++;
      if (instr_done) begin
        done++;
        last_lat = cyc;
        cyc = 0;
        if (done == n) run = 0;
      end
    end
    run = 0;
    if (done < n) chk("run_timeout", done, n);
    repeat (2) @(negedge clk);
  endtask
  typedef struct {
    string nm;
    logic [15:0] a0, ins, opnd, ea, eq, emem;
    logic [11:0] ez;
    logic eovf;
    int lat;
  } vec_t;
  vec_t v [14];
  initial begin
    int d0;
    bit seen;
    logic [15:0] va, vm;
    v[0]  = '{"ad_pos",   16'h0005, 16'h6200, 16'h0003, 16'h0008, 16'h0, 16'h0003, 12'h802, 1'b0, 4};
    v[1]  = '{"ad_ovf",   16'h7FFF, 16'h6200, 16'h0001, 16'h8000, 16'h0, 16'h0001, 12'h802, 1'b1, 4};
    v[2]  = '{"ad_neg",   16'hFFFE, 16'h6200, 16'hFFFD, 16'hFFFC, 16'h0, 16'hFFFD, 12'h802, 1'b0, 4};
    v[3]  = '{"ad_mzero", 16'h0005, 16'h6200, 16'hFFFA, 16'hFFFF, 16'h0, 16'hFFFA, 12'h802, 1'b0, 4};
    v[4]  = '{"ccs_p3",   16'h1111, 16'h1200, 16'h0003, 16'h0002, 16'h0, 16'h0003, 12'h802, 1'b0, 4};
    v[5]  = '{"ccs_p0",   16'h1111, 16'h1200, 16'h0000, 16'h0000, 16'h0, 16'h0000, 12'h803, 1'b0, 4};
    v[6]  = '{"ccs_m3",   16'h1111, 16'h1200, 16'hFFFC, 16'h0002, 16'h0, 16'hFFFC, 12'h804, 1'b0, 4};
    v[7]  = '{"ccs_m0",   16'h1111, 16'h1200, 16'hFFFF, 16'h0000, 16'h0, 16'hFFFF, 12'h805, 1'b0, 4};
    v[8]  = '{"cs",       16'h1111, 16'h4200, 16'h1234, 16'hEDCB, 16'h0, 16'h1234, 12'h802, 1'b0, 4};
    v[9]  = '{"mask",     16'hFF0F, 16'h7200, 16'h0FF0, 16'h0F00, 16'h0, 16'h0FF0, 12'h802, 1'b0, 4};
    v[10] = '{"xch",      16'h1111, 16'h3200, 16'h2222, 16'h2222, 16'h0, 16'h1111, 12'h802, 1'b0, 5};
    v[11] = '{"ts",       16'h4444, 16'h5200, 16'h9999, 16'h4444, 16'h0, 16'h4444, 12'h802, 1'b0, 5};
    v[12] = '{"tc",       16'h1111, 16'h0123, 16'h0000, 16'h1111, 16'h0802, 16'h0000, 12'h123, 1'b0, 3};
    v[13] = '{"index",    16'h1111, 16'h2200, 16'h0005, 16'h1111, 16'h0, 16'h0005, 12'h802, 1'b0, 4};
    clr_mem();
    do_reset();
    chk("rst_a", reg_a, 16'h0);
    chk("rst_q", reg_q, 16'h0);
    chk("rst_z", reg_z, 12'h800);
    chk("rst_ovf", overflow, 0);
    chk("rst_halted", halted, 1);
    chk("rst_done", instr_done, 0);
    chk("rst_req", m.mem_req, 0);
    mem[12'h800] = 16'h0123;
    d0 = done_cnt;
    run_n(1);
    chk("tc_q", reg_q, 16'h0801);
    chk("tc_z", reg_z, 12'h123);
    chk("tc_lat", last_lat, 3);
    chk("tc_done_once", done_cnt - d0, 1);
    mem[12'h123] = 16'h4300;
    mem[12'h300] = 16'hAAAA;
    d0 = done_cnt;
    run = 1;
    repeat (2) @(negedge clk);
    run = 0;
    repeat (8) @(negedge clk);
    chk("stop_done_once", done_cnt - d0, 1);
    chk("stop_halted", halted, 1);
    chk("stop_a", reg_a, 16'h5555);
    chk("stop_z", reg_z, 12'h124);
    foreach (v[i]) begin
      do_reset();
      clr_mem();
      mem[12'h800] = 16'h4300;
      mem[12'h300] = ~v[i].a0;
      mem[12'h801] = v[i].ins;
      mem[12'h200] = v[i].opnd;
      run_n(2);
      chk({v[i].nm, "_a"}, reg_a, v[i].ea);
      chk({v[i].nm, "_q"}, reg_q, v[i].eq);
      chk({v[i].nm, "_z"}, reg_z, v[i].ez);
      chk({v[i].nm, "_ovf"}, overflow, v[i].eovf);
      chk({v[i].nm, "_mem"}, mem[12'h200], v[i].emem);
      chk({v[i].nm, "_lat"}, last_lat, v[i].lat);
      chk({v[i].nm, "_halted"}, halted, 1);
    end
    do_reset();
    clr_mem();
    mem[12'h800] = 16'h4300; mem[12'h300] = 16'h8000;
    mem[12'h801] = 16'h6301; mem[12'h301] = 16'h0001;
    mem[12'h802] = 16'h5010;
    run_n(2);
    chk("ovf_a", reg_a, 16'h8000);
    chk("ovf_set", overflow, 1);
    run_n(1);
    chk("ts_mem", mem[12'h010], 16'h8000);
    chk("ts_skip_z", reg_z, 12'h804);
    chk("ts_ovf_clr", overflow, 0);
    chk("ts_lat", last_lat, 5);
    do_reset();
    clr_mem();
    mem[12'h800] = 16'h2300; mem[12'h300] = 16'h0002;
    mem[12'h801] = 16'h4100; mem[12'h802] = 16'h4100;
    mem[12'h100] = 16'h5555; mem[12'h102] = 16'h00FF;
    run_n(2);
    chk("idx_a", reg_a, 16'hFF00);
    run_n(1);
    chk("idx_clr_a", reg_a, 16'hAAAA);
    chk("idx_clr_z", reg_z, 12'h803);
    rnd_dly = 1;
    for (int t = 0; t < 4; t++) begin
      va = 16'($urandom);
      vm = 16'($urandom);
      do_reset();
      clr_mem();
      mem[12'h800] = 16'h4300; mem[12'h300] = ~va;
      mem[12'h801] = 16'h3020; mem[12'h020] = vm;
      unstable = 0;
      run_n(2);
      chk("rxch_a", reg_a, vm);
      chk("rxch_mem", mem[12'h020], va);
      chk("rxch_stable", unstable, 0);
    end
    rnd_dly = 0;
    do_reset();
    clr_mem();
    mem[12'h800] = 16'h4300; mem[12'h300] = ~16'h1357;
    mem[12'h801] = 16'h3020; mem[12'h020] = 16'h2468;
    wr_dly = 50;
    run = 1;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = m.mem_req && m.mem_we;
    end
    chk("opwr_seen", seen, 1);
    #2 rst_n = 0;
    run = 0;
    #1;
    chk("arst_req", m.mem_req, 0);
    chk("arst_halted", halted, 1);
    chk("arst_z", reg_z, 12'h800);
    repeat (2) @(negedge clk);
    rst_n = 1;
    wr_dly = 0;
    repeat (3) @(negedge clk);
    chk("arst_no_write", mem[12'h020], 16'h2468);
    chk("arst_idle", m.mem_req, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
